reg_file_ctrl: RTL and testbench
================================

// Module: reg_file_ctrl
// PURPOSE
//  Schedules the single-port Wishbone register file between the decode stage (operand pair
//  read rs1/rs2) and the writeback stage (rd write). Serialises requests into single
//  Wishbone transactions, writes before reads, and returns both operands together.
// PARAMETERS
//  AW  5   register index width (32 architectural registers)
//  DW  32  data width
// PORTS
//  i_clk        in   1   clock
//  i_reset      in   1   synchronous, active-high reset
//  i_rd_req     in   1   operand-read request; sampled when o_rd_busy=0
//  i_rs1        in   AW  first operand index
//  i_rs2        in   AW  second operand index
//  o_rd_busy    out  1   read slot occupied
//  o_rd_valid   out  1   one-cycle pulse: o_rs1_data/o_rs2_data valid
//  o_rs1_data   out  DW  operand 1, held until next completion
//  o_rs2_data   out  DW  operand 2, held until next completion
//  i_wr_req     in   1   writeback request; sampled when o_wr_busy=0
//  i_wr_addr    in   AW  destination index
//  i_wr_data    in   DW  writeback data
//  o_wr_busy    out  1   write slot occupied
//  o_wr_done    out  1   one-cycle pulse: write committed
//  o_wb_stb     out  1   Wishbone strobe to reg file
//  o_wb_we      out  1   Wishbone write enable
//  o_wb_addr    out  32  zero-extended register index
//  o_wb_data    out  DW  write data (0 on reads)
//  i_wb_data    in   DW  read data
//  i_wb_ack     in   1   transaction complete
//  i_wb_stall   in   1   slave cannot accept strobe
// BEHAVIOUR
//  - Reset: state S_IDLE, both slots empty, all outputs 0 (operand registers cleared to 0).
//  - Slots: one read slot and one write slot. A request is latched at the clock edge where it is
//    high and its busy is low; busy is high from the next cycle until completion.
//  - FSM: S_IDLE -> S_WR -> S_WR_WAIT -> S_IDLE;
//    S_IDLE -> S_RS1 -> S_RS1_WAIT -> S_RS2 -> S_RS2_WAIT -> S_IDLE.
//    In S_IDLE a pending write is always chosen over a pending read (RAW-safe).
//  - Strobe states hold o_wb_stb=1 with stable we/addr/data while i_wb_stall=1; acceptance occurs
//    when stb && !stall, then move to the _WAIT state with stb=0.
//  - _WAIT: leave only on i_wb_ack. Read data is captured on the ack cycle. Ack outside a
//    _WAIT state is ignored.
//  - A read in progress is never pre-empted; a write latched mid-read runs after it.
//  - Completion: o_wr_done / o_rd_valid are registered, high the cycle after the final ack;
//    the slot frees on that same edge, so a new request may be latched in the pulse cycle.
//  - Timing (team reg file, nonzero indices, request high cycle 0): write stb c1, ack c3,
//    o_wr_done c4; read rs1 stb c1, ack c3, rs2 stb c4, ack c6, o_rd_valid c7.
//  - Simultaneous rd+wr requests: both latched; write completes first, then read.
//  - Reset mid-transaction: abort immediately to S_IDLE, stb low, slots cleared, no pulses.
// CONFIGURATION
//  REG_CTRL_SHORTCUT_EN defined: index 0 is not fetched (returns 0, no bus cycle); rs2==rs1
//    reuses the rs1 result; each skipped fetch costs exactly one cycle in its strobe state with stb=0.
//    Writes to index 0 complete with o_wr_done and no bus cycle.
//  Undefined: every operand is fetched over Wishbone, including index 0 and duplicates.
// STRUCTURE
//  reg_ctrl_pkg: FSM state encoding, AW/DW defaults, WB_ADDR_W=32.
//  Sub-module wb_single_master: issues one stb/stall/ack transaction, returns done + rdata.
// TESTING
//  1. Write x5=0xDEADBEEF -> one stb with we=1, addr=5; o_wr_done in cycle 4.
//  2. Read rs1=5, rs2=6 after preload (x6=0x12345678) -> o_rd_valid c7; 0xDEADBEEF / 0x12345678.
//  3. Same cycle: write x7=0xA5A5A5A5 and read rs1=7, rs2=7 -> write first; both operands 0xA5A5A5A5.
//  4. Slave stall held 3 cycles on rs1 strobe -> stb, addr stable throughout; valid delayed 3 cycles.
//  5. i_reset during S_RS1_WAIT -> next cycle stb=0, busy=0, no o_rd_valid; late ack ignored.
//  6. REG_CTRL_SHORTCUT_EN: read rs1=0, rs2=0 -> no stb, o_rd_valid c3, both operands 0.

Source files
------------

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-file access controller.
// Holds the default widths, the Wishbone address width, and the FSM state
// encoding that the controller exposes on its debug port.
package reg_ctrl_pkg;

  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;
  localparam int WB_ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RS1      = 3'd3,
    S_RS1_WAIT = 3'd4,
    S_RS2      = 3'd5,
    S_RS2_WAIT = 3'd6
  } state_t;

endpackage

// File: rtl/wb_single_master.sv
// Wishbone single-transaction front end.
// The controller FSM says which phase it is in (strobe or wait) and what to
// send; this block drives the bus and reports acceptance and completion.
// Ports:
//   strobe_i  : FSM is in a strobe state and wants the bus cycle issued
//   wait_i    : FSM is in a wait state, waiting for the ack
//   we_i, addr_i, wdata_i : transaction contents
//   accept_o  : strobe accepted this cycle (stb && !stall)
//   done_o    : ack seen while waiting
//   rdata_o   : read data, valid together with done_o
//   wb_*      : Wishbone master signals / slave responses
module wb_single_master
  import reg_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 strobe_i,
  input  logic                 wait_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [DW-1:0]        wdata_i,
  output logic                 accept_o,
  output logic                 done_o,
  output logic [DW-1:0]        rdata_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [WB_ADDR_W-1:0] wb_addr_o,
  output logic [DW-1:0]        wb_data_o,
  input  logic [DW-1:0]        wb_data_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_stall_i
);

  // Everything is qualified by the strobe so the bus is all-zero when idle;
  // contents come straight from the controller's slot registers, so they
  // stay stable for as long as the slave stalls.
  assign wb_stb_o  = strobe_i;
  assign wb_we_o   = strobe_i & we_i;
  assign wb_addr_o = strobe_i ? {{(WB_ADDR_W-AW){1'b0}}, addr_i} : '0;
  assign wb_data_o = (strobe_i && we_i) ? wdata_i : '0;

  assign accept_o = strobe_i & ~wb_stall_i;
  // Acks arriving outside a wait phase are ignored.
  assign done_o   = wait_i & wb_ack_i;
  assign rdata_o  = wb_data_i;

endmodule

// File: rtl/reg_file_ctrl.sv
// Register-file access scheduler.
// Serialises the decode stage's operand-pair read (rs1/rs2) and the writeback
// stage's rd write onto a single-port Wishbone register file. Pending writes
// always go before pending reads; a read in progress is never pre-empted.
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_rd_req/i_rs1/i_rs2 : operand read request, taken when o_rd_busy=0
//   o_rd_busy            : read slot occupied
//   o_rd_valid           : one-cycle pulse, o_rs1_data/o_rs2_data updated
//   i_wr_req/i_wr_addr/i_wr_data : writeback request, taken when o_wr_busy=0
//   o_wr_busy, o_wr_done : write slot occupied / one-cycle commit pulse
//   o_wb_*, i_wb_*       : Wishbone master port
//   o_dbg_state          : current FSM state (reg_ctrl_pkg::state_t)
// Handshake: a request is captured on the edge where req=1 and busy=0; busy
// then stays high until the edge that raises the completion pulse.
// Build option: REG_CTRL_SHORTCUT_EN skips bus cycles for index 0 and for
// rs2 equal to rs1 (one cycle spent in the strobe state with stb low).
module reg_file_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rd_req,
  input  logic [AW-1:0]        i_rs1,
  input  logic [AW-1:0]        i_rs2,
  output logic                 o_rd_busy,
  output logic                 o_rd_valid,
  output logic [DW-1:0]        o_rs1_data,
  output logic [DW-1:0]        o_rs2_data,
  input  logic                 i_wr_req,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [DW-1:0]        i_wr_data,
  output logic                 o_wr_busy,
  output logic                 o_wr_done,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [WB_ADDR_W-1:0] o_wb_addr,
  output logic [DW-1:0]        o_wb_data,
  input  logic [DW-1:0]        i_wb_data,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  output logic [2:0]           o_dbg_state
);

  state_t          state_q, state_d;
  logic            wr_pend_q, wr_pend_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            rd_pend_q, rd_pend_d;
  logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DW-1:0]   rs1_tmp_q, rs1_tmp_d;
  logic [DW-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic            rd_valid_q, rd_valid_d, wr_done_q, wr_done_d;

  logic            bus_strobe, bus_wait, bus_we, bus_accept, bus_done;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata, bus_rdata;

  logic            skip_wr, skip_rs1, skip_rs2;
  logic [DW-1:0]   rs2_skip_val;

`ifdef REG_CTRL_SHORTCUT_EN
  assign skip_wr      = (wr_addr_q == '0);
  assign skip_rs1     = (rs1_q == '0);
  assign skip_rs2     = (rs2_q == '0) || (rs2_q == rs1_q);
  // rs1 result is already in rs1_tmp_q (fetched or forced to 0).
  assign rs2_skip_val = (rs2_q == '0) ? '0 : rs1_tmp_q;
`else
  assign skip_wr      = 1'b0;
  assign skip_rs1     = 1'b0;
  assign skip_rs2     = 1'b0;
  assign rs2_skip_val = '0;
`endif

  wb_single_master #(.AW(AW), .DW(DW)) u_wb (
    .strobe_i  (bus_strobe),
    .wait_i    (bus_wait),
    .we_i      (bus_we),
    .addr_i    (bus_addr),
    .wdata_i   (bus_wdata),
    .accept_o  (bus_accept),
    .done_o    (bus_done),
    .rdata_o   (bus_rdata),
    .wb_stb_o  (o_wb_stb),
    .wb_we_o   (o_wb_we),
    .wb_addr_o (o_wb_addr),
    .wb_data_o (o_wb_data),
    .wb_data_i (i_wb_data),
    .wb_ack_i  (i_wb_ack),
    .wb_stall_i(i_wb_stall)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_pend_q  <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_tmp_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_pend_q  <= rd_pend_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rs1_tmp_q  <= rs1_tmp_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_pend_d  = wr_pend_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_pend_d  = rd_pend_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs1_tmp_d  = rs1_tmp_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    bus_strobe = 1'b0;
    bus_wait   = 1'b0;
    bus_we     = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;

    // Slot capture. Completion only clears a slot that is already full, so
    // it never collides with a capture on the same edge.
    if (i_wr_req && !wr_pend_q) begin
      wr_pend_d = 1'b1;
      wr_addr_d = i_wr_addr;
      wr_data_d = i_wr_data;
    end
    if (i_rd_req && !rd_pend_q) begin
      rd_pend_d = 1'b1;
      rs1_d     = i_rs1;
      rs2_d     = i_rs2;
    end

    unique case (state_q)
      // Requests arriving this cycle count as pending, so a fresh request
      // reaches its strobe state on the very next cycle.
      S_IDLE: begin
        if (wr_pend_q || i_wr_req)      state_d = S_WR;
        else if (rd_pend_q || i_rd_req) state_d = S_RS1;
      end
      S_WR: begin
        bus_we    = 1'b1;
        bus_addr  = wr_addr_q;
        bus_wdata = wr_data_q;
        if (skip_wr) begin
          wr_pend_d = 1'b0;
          wr_done_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          bus_strobe = 1'b1;
          if (bus_accept) state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        bus_wait = 1'b1;
        if (bus_done) begin
          wr_pend_d = 1'b0;
          wr_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_RS1: begin
        bus_addr = rs1_q;
        if (skip_rs1) begin
          rs1_tmp_d = '0;
          state_d   = S_RS2;
        end else begin
          bus_strobe = 1'b1;
          if (bus_accept) state_d = S_RS1_WAIT;
        end
      end
      S_RS1_WAIT: begin
        bus_wait = 1'b1;
        if (bus_done) begin
          rs1_tmp_d = bus_rdata;
          state_d   = S_RS2;
        end
      end
      S_RS2: begin
        bus_addr = rs2_q;
        if (skip_rs2) begin
          rs1_data_d = rs1_tmp_q;
          rs2_data_d = rs2_skip_val;
          rd_valid_d = 1'b1;
          rd_pend_d  = 1'b0;
          state_d    = S_IDLE;
        end else begin
          bus_strobe = 1'b1;
          if (bus_accept) state_d = S_RS2_WAIT;
        end
      end
      S_RS2_WAIT: begin
        bus_wait = 1'b1;
        if (bus_done) begin
          // Both operands update together so the outputs never show a mix
          // of old and new values.
          rs1_data_d = rs1_tmp_q;
          rs2_data_d = bus_rdata;
          rd_valid_d = 1'b1;
          rd_pend_d  = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rd_busy   = rd_pend_q;
  assign o_wr_busy   = wr_pend_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_wr_done   = wr_done_q;
  assign o_rs1_data  = rs1_data_q;
  assign o_rs2_data  = rs2_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Bench for reg_file_ctrl: a Wishbone slave model (ack two cycles after the
// accepted strobe), a reference register image, and an expected-operand
// queue checked on every o_rd_valid pulse.
module tb_reg_file_ctrl;
  import reg_ctrl_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           i_reset;
  logic           i_rd_req;
  logic [AW-1:0]  i_rs1, i_rs2;
  logic           o_rd_busy, o_rd_valid;
  logic [DW-1:0]  o_rs1_data, o_rs2_data;
  logic           i_wr_req;
  logic [AW-1:0]  i_wr_addr;
  logic [DW-1:0]  i_wr_data;
  logic           o_wr_busy, o_wr_done;
  logic           o_wb_stb, o_wb_we;
  logic [31:0]    o_wb_addr;
  logic [DW-1:0]  o_wb_data, i_wb_data;
  logic           i_wb_ack, i_wb_stall;
  logic [2:0]     o_dbg_state;

  reg_file_ctrl #(.AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_rd_req(i_rd_req), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_rd_busy(o_rd_busy), .o_rd_valid(o_rd_valid),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_busy(o_wr_busy), .o_wr_done(o_wr_done),
    .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack),
    .i_wb_stall(i_wb_stall), .o_dbg_state(o_dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] slave_mem [32];
  logic [DW-1:0] ref_regs  [32];
  logic [2*DW-1:0] exp_q [$];

  // ---------------- Wishbone slave model ----------------
  int            ack_dly = 0;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wdata;

  initial begin
    i_wb_ack  = 1'b0;
    i_wb_data = '0;
    forever begin
      @(negedge clk);
      if (o_wb_stb && !i_wb_stall) begin
        s_addr  = o_wb_addr[AW-1:0];
        s_we    = o_wb_we;
        s_wdata = o_wb_data;
        ack_dly = 2;
      end
      @(posedge clk); #1;
      i_wb_ack  = 1'b0;
      i_wb_data = '0;
      if (ack_dly > 0) begin
        ack_dly--;
        if (ack_dly == 0) begin
          i_wb_ack = 1'b1;
          if (s_we) slave_mem[s_addr] = s_wdata;
          else      i_wb_data = slave_mem[s_addr];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (o_rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_valid_unexpected: got rs1=%h rs2=%h, required no pulse", o_rs1_data, o_rs2_data);
      end else begin
        logic [2*DW-1:0] e;
        e = exp_q.pop_front();
        if ({o_rs1_data, o_rs2_data} !== e) begin
          n_err++;
          $display("FAIL operands: got %h/%h, required %h/%h", o_rs1_data, o_rs2_data, e[2*DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Called at the start of cycle start_cyc; returns at the negedge of the
  // cycle in which the selected pulse is seen, or cyc=-1 after limit.
  task automatic wait_evt(input bit rd, input int start_cyc, input int limit,
                          output int cyc, output int stbs);
    cyc  = start_cyc;
    stbs = 0;
    forever begin
      @(negedge clk);
      if (o_wb_stb) stbs++;
      if (rd ? o_rd_valid : o_wr_done) return;
      if (cyc >= limit) begin cyc = -1; return; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int cyc, output int stbs);
    tick();
    i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d;
    ref_regs[a] = d;
    tick();
    i_wr_req = 1'b0;
    wait_evt(1'b0, 1, 40, cyc, stbs);
  endtask

  task automatic do_read(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         output int cyc, output int stbs);
    tick();
    i_rd_req = 1'b1; i_rs1 = r1; i_rs2 = r2;
    exp_q.push_back({ref_regs[r1], ref_regs[r2]});
    tick();
    i_rd_req = 1'b0;
    wait_evt(1'b1, 1, 60, cyc, stbs);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({o_rd_busy, o_wr_busy, o_rd_valid, o_wr_done, o_wb_stb, o_wb_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 000000",
               {o_rd_busy, o_wr_busy, o_rd_valid, o_wr_done, o_wb_stb, o_wb_we});
    end
    n_cmp++;
    if ({o_wb_addr, o_wb_data, o_rs1_data, o_rs2_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wdata=%h rs1=%h rs2=%h, required all 0",
               o_wb_addr, o_wb_data, o_rs1_data, o_rs2_data);
    end
    n_cmp++;
    if (o_dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required %0d", o_dbg_state, S_IDLE);
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic test_write();
    int cyc, stbs;
    tick();
    i_wr_req = 1'b1; i_wr_addr = 5'd5; i_wr_data = 32'hDEADBEEF;
    ref_regs[5] = 32'hDEADBEEF;
    tick();
    i_wr_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wr_busy} !== {1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1}) begin
      n_err++;
      $display("FAIL write_strobe: got stb=%b we=%b addr=%h data=%h busy=%b, required 1 1 00000005 deadbeef 1",
               o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wr_busy);
    end
    @(posedge clk); #1;
    wait_evt(1'b0, 2, 40, cyc, stbs);
    n_cmp++;
    if (cyc !== 4 || stbs !== 0) begin
      n_err++;
      $display("FAIL write_done_cycle: got cycle %0d extra_stb %0d, required 4 and 0", cyc, stbs);
    end
  endtask

  task automatic test_read();
    int cyc, stbs;
    do_write(5'd6, 32'h12345678, cyc, stbs);
    n_cmp++;
    if (cyc !== 4 || stbs !== 1) begin
      n_err++;
      $display("FAIL preload_write: got cycle %0d stb %0d, required 4 and 1", cyc, stbs);
    end
    do_read(5'd5, 5'd6, cyc, stbs);
    n_cmp++;
    if (cyc !== 7 || stbs !== 2) begin
      n_err++;
      $display("FAIL read_timing: got cycle %0d stb %0d, required 7 and 2", cyc, stbs);
    end
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({o_rs1_data, o_rs2_data} !== {32'hDEADBEEF, 32'h12345678}) begin
      n_err++;
      $display("FAIL operand_hold: got %h/%h, required deadbeef/12345678", o_rs1_data, o_rs2_data);
    end
  endtask

  task automatic test_simultaneous();
    int cyc, stbs, exp_rd;
`ifdef REG_CTRL_SHORTCUT_EN
    exp_rd = 9;
`else
    exp_rd = 11;
`endif
    tick();
    i_wr_req = 1'b1; i_wr_addr = 5'd7; i_wr_data = 32'hA5A5A5A5;
    i_rd_req = 1'b1; i_rs1 = 5'd7; i_rs2 = 5'd7;
    exp_q.push_back({32'hA5A5A5A5, 32'hA5A5A5A5});
    ref_regs[7] = 32'hA5A5A5A5;
    tick();
    i_wr_req = 1'b0; i_rd_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_wb_stb, o_wb_we, o_rd_busy, o_wr_busy} !== 4'b1111) begin
      n_err++;
      $display("FAIL simul_first: got stb=%b we=%b rd_busy=%b wr_busy=%b, required 1111",
               o_wb_stb, o_wb_we, o_rd_busy, o_wr_busy);
    end
    @(posedge clk); #1;
    wait_evt(1'b0, 2, 40, cyc, stbs);
    n_cmp++;
    if (cyc !== 4) begin
      n_err++;
      $display("FAIL simul_wr_done: got cycle %0d, required 4", cyc);
    end
    @(posedge clk); #1;
    wait_evt(1'b1, 5, 60, cyc, stbs);
    n_cmp++;
    if (cyc !== exp_rd) begin
      n_err++;
      $display("FAIL simul_rd_valid: got cycle %0d, required %0d", cyc, exp_rd);
    end
  endtask

  task automatic test_stall();
    int cyc, stbs;
    tick();
    i_wb_stall = 1'b1;
    i_rd_req = 1'b1; i_rs1 = 5'd5; i_rs2 = 5'd6;
    exp_q.push_back({ref_regs[5], ref_regs[6]});
    tick();
    i_rd_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({o_wb_stb, o_wb_we, o_wb_addr} !== {1'b1, 1'b0, 32'd5}) begin
        n_err++;
        $display("FAIL stall_hold_c%0d: got stb=%b we=%b addr=%h, required 1 0 00000005",
                 k, o_wb_stb, o_wb_we, o_wb_addr);
      end
      @(posedge clk); #1;
    end
    i_wb_stall = 1'b0;
    wait_evt(1'b1, 4, 60, cyc, stbs);
    n_cmp++;
    if (cyc !== 10 || stbs !== 2) begin
      n_err++;
      $display("FAIL stall_timing: got cycle %0d stb %0d, required 10 and 2", cyc, stbs);
    end
  endtask

  task automatic test_reset_midread();
    int cyc, stbs, bad;
    tick();
    i_rd_req = 1'b1; i_rs1 = 5'd3; i_rs2 = 5'd4;
    tick();
    i_rd_req = 1'b0;
    tick();
    i_reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_dbg_state !== S_RS1_WAIT) begin
      n_err++;
      $display("FAIL midread_state: got %0d, required %0d", o_dbg_state, S_RS1_WAIT);
    end
    tick();
    i_reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({o_wb_stb, o_rd_busy, o_rd_valid} !== 3'b000 || o_dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_abort: got stb=%b busy=%b valid=%b state=%0d, required 0 0 0 %0d",
               o_wb_stb, o_rd_busy, o_rd_valid, o_dbg_state, S_IDLE);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_wb_stb || o_rd_valid || o_rd_busy || o_dbg_state !== S_IDLE) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL late_ack_ignored: got %0d active cycles, required 0", bad);
    end
    do_read(5'd3, 5'd4, cyc, stbs);
    n_cmp++;
    if (cyc !== 7) begin
      n_err++;
      $display("FAIL read_after_abort: got cycle %0d, required 7", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, stbs;
    do_read(5'd8, 5'd9, cyc, stbs);
    n_cmp++;
    if (o_rd_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_busy_in_pulse: got %b, required 0", o_rd_busy);
    end
    // Request placed in the pulse cycle itself.
    i_rd_req = 1'b1; i_rs1 = 5'd10; i_rs2 = 5'd11;
    exp_q.push_back({ref_regs[10], ref_regs[11]});
    @(posedge clk); #1;
    i_rd_req = 1'b0;
    wait_evt(1'b1, 1, 60, cyc, stbs);
    n_cmp++;
    if (cyc !== 7) begin
      n_err++;
      $display("FAIL b2b_timing: got cycle %0d, required 7", cyc);
    end
  endtask

  task automatic test_random();
    int cyc, stbs;
    logic [AW-1:0] a, r1, r2;
    for (int k = 0; k < 6; k++) begin
      a = AW'($urandom_range(1, 31));
      do_write(a, $urandom, cyc, stbs);
      n_cmp++;
      if (cyc !== 4) begin
        n_err++;
        $display("FAIL rand_write_%0d: got cycle %0d, required 4", k, cyc);
      end
      r1 = AW'($urandom_range(1, 31));
      r2 = (k == 0) ? a : AW'($urandom_range(1, 31));
      do_read(r1, r2, cyc, stbs);
      n_cmp++;
      if (cyc < 0) begin
        n_err++;
        $display("FAIL rand_read_%0d: timed out, required o_rd_valid", k);
      end
    end
  endtask

  task automatic test_index_zero();
    int cyc, stbs;
`ifdef REG_CTRL_SHORTCUT_EN
    ref_regs[0] = '0;
    do_read(5'd0, 5'd0, cyc, stbs);
    n_cmp++;
    if (cyc !== 3 || stbs !== 0) begin
      n_err++;
      $display("FAIL zero_read: got cycle %0d stb %0d, required 3 and 0", cyc, stbs);
    end
    do_write(5'd0, 32'hFFFF0000, cyc, stbs);
    ref_regs[0] = '0;
    n_cmp++;
    if (cyc !== 2 || stbs !== 0) begin
      n_err++;
      $display("FAIL zero_write: got cycle %0d stb %0d, required 2 and 0", cyc, stbs);
    end
`else
    do_read(5'd0, 5'd0, cyc, stbs);
    n_cmp++;
    if (cyc !== 7 || stbs !== 2) begin
      n_err++;
      $display("FAIL zero_read: got cycle %0d stb %0d, required 7 and 2", cyc, stbs);
    end
`endif
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    i_reset = 1'b1; i_rd_req = 1'b0; i_rs1 = '0; i_rs2 = '0;
    i_wr_req = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_wb_stall = 1'b0;
    for (int i = 0; i < 32; i++) begin
      slave_mem[i] = $urandom;
      ref_regs[i]  = slave_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_stall();
    test_reset_midread();
    test_back_to_back();
    test_random();
    test_index_zero();
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
